// File: rtl/arb_pkg.sv
// Shared types and width helpers for the memory-port arbiter.
package arb_pkg;

   // Arbiter controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      if (n <= 32'sd2) begin
         return 32'sd1;
      end else begin
         return $clog2(n);
      end
   endfunction

   // Width of an owner index for a given number of requesters.
   function automatic int owner_w(input int num_req);
      return clog2_min1(num_req);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// last_owner, wrapping modulo NUM_REQ.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int OWNER_W = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWNER_W-1:0] last_owner,
   output logic               valid,
   output logic [OWNER_W-1:0] winner
);

   localparam logic [OWNER_W-1:0] OWNER_LAST = OWNER_W'(NUM_REQ - 32'sd1);

   logic [OWNER_W-1:0] cand_s;

   // Walk the candidates starting one past the previous owner; the first hit wins.
   always_comb begin
      cand_s = last_owner;
      valid  = 1'b0;
      winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cand_s == OWNER_LAST) begin
            cand_s = '0;
         end else begin
            cand_s = cand_s + OWNER_W'(1);
         end
         if (!valid && req[cand_s]) begin
            valid  = 1'b1;
            winner = cand_s;
         end else begin
            valid  = valid;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among NUM_REQ masters with round-robin arbitration,
// an optional owner lock for atomic back-to-back sequences, and a bounded
// wait for mem_ready. All outputs come straight from flops.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_wr,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        err,
   output logic [DATA_W-1:0]         rdata,
   output logic                      mem_rd,
   output logic                      mem_wr,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_ready
);

   localparam int OWNER_W = owner_w(NUM_REQ);
   localparam int CNT_W   = clog2_min1(MAX_WAIT);
   localparam bit TIMEOUT_EN = (MAX_WAIT > 32'sd0);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_EN ? (MAX_WAIT - 32'sd1) : 32'sd0);
   localparam logic [OWNER_W-1:0] OWNER_LAST = OWNER_W'(NUM_REQ - 32'sd1);

   arb_state_e          state_q, state_d;
   logic [OWNER_W-1:0]  owner_q, owner_d;
   logic [OWNER_W-1:0]  last_q, last_d;
   logic                wr_q, wr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                mem_rd_q, mem_rd_d;
   logic                mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [OWNER_W-1:0]  rr_last_s;
   logic                pick_valid_s;
   logic [OWNER_W-1:0]  pick_idx_s;
   logic                lock_keep_s;
   logic                win_valid_s;
   logic [OWNER_W-1:0]  win_idx_s;
   logic                win_wr_s;
   logic [ADDR_W-1:0]   win_addr_s;
   logic [DATA_W-1:0]   win_wdata_s;
   logic [NUM_REQ-1:0]  win_onehot_s;
   logic [NUM_REQ-1:0]  owner_onehot_s;

   // In DONE the finishing owner is the reference point for fairness, even
   // before last_owner has been updated to it.
   always_comb begin
      if (state_q == DONE) begin
         rr_last_s = owner_q;
      end else begin
         rr_last_s = last_q;
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .OWNER_W (OWNER_W)
   ) u_rr (
      .req        (req),
      .last_owner (rr_last_s),
      .valid      (pick_valid_s),
      .winner     (pick_idx_s)
   );

   // A locked owner that still requests keeps the port; otherwise round-robin decides.
   always_comb begin
      lock_keep_s = (state_q == DONE) && req_lock[owner_q] && req[owner_q];
      if (lock_keep_s) begin
         win_valid_s = 1'b1;
         win_idx_s   = owner_q;
      end else begin
         win_valid_s = pick_valid_s;
         win_idx_s   = pick_idx_s;
      end
   end

   // Select the winner's command fields and build one-hot owner vectors.
   always_comb begin
      win_wr_s       = 1'b0;
      win_addr_s     = '0;
      win_wdata_s    = '0;
      win_onehot_s   = '0;
      owner_onehot_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (OWNER_W'(i) == win_idx_s) begin
            win_wr_s        = req_wr[i];
            win_addr_s      = req_addr[i*ADDR_W +: ADDR_W];
            win_wdata_s     = req_wdata[i*DATA_W +: DATA_W];
            win_onehot_s[i] = 1'b1;
         end else begin
            win_onehot_s[i] = 1'b0;
         end
         if (OWNER_W'(i) == owner_q) begin
            owner_onehot_s[i] = 1'b1;
         end else begin
            owner_onehot_s[i] = 1'b0;
         end
      end
   end

   // Next-state and registered-output logic for the IDLE/ACCESS/DONE controller.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      ack_d       = '0;
      err_d       = '0;
      rdata_d     = rdata_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE, DONE: begin
            if ((state_q == DONE) && !lock_keep_s) begin
               last_d = owner_q;
            end else begin
               last_d = last_q;
            end
            if (win_valid_s) begin
               state_d     = ACCESS;
               owner_d     = win_idx_s;
               wr_d        = win_wr_s;
               cnt_d       = '0;
               gnt_d       = win_onehot_s;
               mem_rd_d    = ~win_wr_s;
               mem_wr_d    = win_wr_s;
               mem_addr_d  = win_addr_s;
               mem_wdata_d = win_wdata_s;
            end else begin
               state_d  = IDLE;
               gnt_d    = '0;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               state_d  = DONE;
               ack_d    = owner_onehot_s;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               if (!wr_q) begin
                  rdata_d = mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
               state_d  = DONE;
               err_d    = owner_onehot_s;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset points last_owner at the top index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         last_q      <= OWNER_LAST;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         ack_q       <= '0;
         err_q       <= '0;
         rdata_q     <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign gnt       = gnt_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between NUM_REQ requesters: CPU control fetch/data path, loader/DMA, and debug.
- Uses round-robin arbitration with an optional per-requester lock for back-to-back atomic sequences.
- Applies a bounded wait-state timeout.
- Sits between the control-unit memory strobes (plus other masters) and the memory/MAR-MDR side.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 16, cycles to wait for mem_ready before an error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request, held high by the requester until its ack or err.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  keep the grant for the next request from the same owner.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot current owner.
- ack  out  NUM_REQ  one-cycle completion pulse.
- err  out  NUM_REQ  one-cycle timeout pulse.
- rdata  out  DATA_W  last completed read data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the access this cycle.

Behaviour:
- Reset (async, any state, mid-access included):
  - State = IDLE.
  - gnt, ack, err, mem_rd, mem_wr = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - wait counter = 0.
  - last_owner = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, ACCESS, DONE.
- Arbitration, evaluated in IDLE and DONE:
  - Lock rule: if in DONE, req_lock[owner] and req[owner] are high, the owner is kept.
  - Otherwise the first asserted req scanning from last_owner+1 modulo NUM_REQ wins.
- On a win:
  - Register owner, req_wr, addr and wdata of the winner.
  - Clear the wait counter and go to ACCESS.
  - gnt[owner] is high from the first ACCESS cycle through the DONE cycle.
- No request: go to (or stay in) IDLE with gnt = 0.
- ACCESS:
  - mem_rd = ~wr and mem_wr = wr, both driven from registers, with mem_addr/mem_wdata stable for the whole access.
  - mem_ready = 1: if read, rdata <= mem_rdata; set ack[owner] for the next cycle; go to DONE.
  - Else if MAX_WAIT != 0 and the counter reaches MAX_WAIT-1: set err[owner] for the next cycle and go to DONE; rdata is unchanged.
  - Else the counter increments.
  - mem_ready and timeout in the same cycle: ready wins (ack, no err).
- DONE:
  - Strobes low; ack/err high exactly this cycle.
  - last_owner <= owner unless the lock is kept.
  - Arbitration runs here, so back-to-back traffic needs no IDLE bubble.
- Latency: req high at cycle 0 in IDLE → strobe cycles 1..k with mem_ready at k → ack at k+1. Minimum 2 cycles, zero wait states.
- rdata holds until the next successful read; writes and errors leave it unchanged.
- Requester drops req during ACCESS: the access still completes and ack/err is still issued (committed transaction).
- Inputs of non-owners are ignored during ACCESS.
- req_lock is sampled only in DONE. A locked owner with req low releases the grant normally.
- Fairness: with all req high and no lock, the grant order is 0,1,…,NUM_REQ-1,0.
- Invariants: gnt, ack and err are each one-hot or zero; mem_rd & mem_wr never both high.

Decomposition:
- arb_pkg:
  - arb_state_e {IDLE, ACCESS, DONE}.
  - Width constant OWNER_W = $clog2(NUM_REQ) (min 1).
- Sub-module rr_arbiter:
  - Combinational round-robin picker.
  - Inputs: req vector, last_owner.
  - Outputs: valid, winner index.
- The FSM, latches, wait counter and pulse generation stay in mem_arbiter.

Test Plan:
- Single read: req[0]=1, wr=0, addr=0x10; mem_ready in 1st strobe cycle with rdata 0xDEADBEEF → mem_rd cycle 1, ack[0] cycle 2, rdata=0xDEADBEEF, gnt[0] cycles 1-2.
- Round-robin: req=2'b11 continuously, mem_ready always 1, NUM_REQ=2 → grants alternate 0,1,0,1; acks every 2 cycles; no IDLE cycles.
- Lock: req_lock[1]=1 for 3 requests while req[0]=1 → requester 1 served 3 times consecutively, then requester 0.
- Timeout: MAX_WAIT=4, mem_ready=0 → exactly 4 strobe cycles, err[0] pulse, no ack, rdata unchanged; next request proceeds normally.
- Wait states + write: req_wr[1]=1, wdata 0x12345678, mem_ready after 3 cycles → mem_wr, mem_addr and mem_wdata stable for all 3 cycles; ack[1] once; rdata unchanged.
- Reset mid-ACCESS: assert rst_n=0 during a strobe → all outputs 0 immediately (asynchronous); after release, requester 0 wins first.
